// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write-port arbiter and vector-load gather.
package rf_pkg;
    localparam int LANES = 16;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int LW    = $clog2(LANES);

    typedef logic [LANES-1:0][DW-1:0] vec_t;

    localparam logic [2:0] CMD_VWRITE  = 3'b000;
    // Redirects the write to the scalar file; the load path must never emit it.
    localparam logic [2:0] CMD_VSCALAR = 3'b101;

    typedef enum logic [1:0] {IDLE, FILL, PEND} ld_state_e;
endpackage

// File: rtl/rf_vload_arbiter_if.sv
// Writeback, vector-load stream and register-file write-port bundle.
interface rf_vload_arbiter_if;
    import rf_pkg::*;

    logic                wb_we;
    logic [AW-1:0]       wb_addr;
    vec_t                wb_data;
    logic                wb_vec;
    logic [2:0]          wb_cmd;
    logic                wb_stall;

    logic                ld_start;
    logic [AW-1:0]       ld_dst;
    logic                ld_valid;
    logic                ld_ready;
    logic [DW-1:0]       ld_data;
    logic                ld_last;
    logic                ld_done;
    logic                ld_err;
    logic [(1<<AW)-1:0]  busy_vec;

    logic                rf_we;
    logic [AW-1:0]       rf_ra3;
    vec_t                rf_wd3;
    logic                rf_vs_w;
    logic [2:0]          rf_cmd;

    modport slave (
        input  wb_we, wb_addr, wb_data, wb_vec, wb_cmd,
        input  ld_start, ld_dst, ld_valid, ld_data, ld_last,
        output wb_stall, ld_ready, ld_done, ld_err, busy_vec,
        output rf_we, rf_ra3, rf_wd3, rf_vs_w, rf_cmd
    );

    modport master (
        output wb_we, wb_addr, wb_data, wb_vec, wb_cmd,
        output ld_start, ld_dst, ld_valid, ld_data, ld_last,
        input  wb_stall, ld_ready, ld_done, ld_err, busy_vec,
        input  rf_we, rf_ra3, rf_wd3, rf_vs_w, rf_cmd
    );
endinterface

// File: rtl/rf_vload_arbiter_vload_gather.sv
// Gathers load words into a zero-filled lane buffer; one word per cycle while filling.
// ld_ready follows the fill phase, so it drops the cycle after the final accept.
module vload_gather
    import rf_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          fill,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic          fill_done,
    output vec_t          buffer
);
    logic [LW-1:0] lane;
    logic          accept;

    assign ld_ready  = fill;
    assign accept    = fill & ld_valid;
    assign fill_done = accept & (ld_last | (lane == LW'(LANES - 1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane   <= '0;
            buffer <= '0;
        end else if (clr) begin
            lane   <= '0;
            buffer <= '0;
        end else if (accept) begin
            buffer[lane] <= ld_data;
            lane         <= lane + LW'(1);
        end
    end
endmodule

// File: rtl/rf_vload_arbiter.sv
// Shares the RF write port between writeback (priority, zero latency) and a gathered vector load.
// A blocked load raises wb_stall after STARVE_MAX lost cycles; busy_vec marks in-flight destinations.
module rf_vload_arbiter
    import rf_pkg::*;
#(
    parameter int STARVE_MAX = 8
) (
    input  logic                clk,
    input  logic                rst,
    rf_vload_arbiter_if.slave   bus
);
    ld_state_e          state_q, state_d;
    logic [AW-1:0]      dst;
    logic [7:0]         starve;
    logic [(1<<AW)-1:0] busy;
    logic               start_ok, grant, fill_done;
    vec_t               buffer;

    vload_gather u_gather (
        .clk       (clk),
        .rst       (rst),
        .clr       (start_ok),
        .fill      (state_q == FILL),
        .ld_valid  (bus.ld_valid),
        .ld_data   (bus.ld_data),
        .ld_last   (bus.ld_last),
        .ld_ready  (bus.ld_ready),
        .fill_done (fill_done),
        .buffer    (buffer)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        start_ok = 1'b0;
        grant    = 1'b0;
        case (state_q)
            IDLE: if (bus.ld_start) begin
                start_ok = 1'b1;
                state_d  = FILL;
            end
            FILL: if (fill_done) state_d = PEND;
            PEND: if (!bus.wb_we) begin
                grant   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dst    <= '0;
            starve <= '0;
            busy   <= '0;
        end else begin
            if (start_ok) begin
                dst               <= bus.ld_dst;
                busy[bus.ld_dst]  <= 1'b1;
            end
            if (grant) begin
                busy[dst] <= 1'b0;
                starve    <= '0;
            end else if (state_q == PEND && bus.wb_we && starve != 8'(STARVE_MAX)) begin
                starve <= starve + 8'd1;
            end
        end
    end

    assign bus.ld_done  = grant;
    assign bus.ld_err   = bus.ld_start & (state_q != IDLE);
    assign bus.busy_vec = busy;
    assign bus.wb_stall = (state_q == PEND) && (starve == 8'(STARVE_MAX));

    // Writeback always wins; the load only drives the port in a free PEND cycle.
    always_comb begin
        bus.rf_we   = 1'b0;
        bus.rf_ra3  = '0;
        bus.rf_wd3  = '0;
        bus.rf_vs_w = 1'b0;
        bus.rf_cmd  = 3'b000;
        if (bus.wb_we) begin
            bus.rf_we   = 1'b1;
            bus.rf_ra3  = bus.wb_addr;
            bus.rf_wd3  = bus.wb_data;
            bus.rf_vs_w = bus.wb_vec;
            bus.rf_cmd  = bus.wb_cmd;
        end else if (state_q == PEND) begin
            bus.rf_we   = 1'b1;
            bus.rf_ra3  = dst;
            bus.rf_wd3  = buffer;
            bus.rf_vs_w = 1'b1;
            bus.rf_cmd  = CMD_VWRITE;
        end
    end
endmodule

// File: doc/rf_vload_arbiter.md
Name: rf_vload_arbiter

Overview:
- Shares the register file's single write port (we3/ra3/wd3/selec_v_s_w/cmd) between two requesters: the core writeback stage and a vector-load stream.
- The vector-load stream delivers 32-bit words from memory. This block gathers them into a 16-lane buffer and then writes the whole vector register in one cycle.
- Writeback always has priority. A starvation counter requests a pipeline stall so a pending load eventually drains.
- A per-register busy scoreboard lets decode interlock on vector registers that have a load in flight.

Parameters:
- LANES, 16, lanes per vector register.
- DW, 32, lane/word width.
- AW, 4, register address width.
- STARVE_MAX, 8, cycles a pending load may be blocked before wb_stall asserts (1..255).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- wb_we  in  1  writeback write request.
- wb_addr  in  AW  writeback destination.
- wb_data  in  LANES*DW  writeback data; lane 15 is the scalar lane.
- wb_vec  in  1  writeback targets the vector file.
- wb_cmd  in  3  writeback cmd, passed through.
- wb_stall  out  1  request to the pipeline to hold writeback.
- ld_start  in  1  pulse that starts a vector load.
- ld_dst  in  AW  destination vector register, sampled on ld_start.
- ld_valid  in  1  load word valid.
- ld_ready  out  1  load word accepted.
- ld_data  in  DW  load word.
- ld_last  in  1  final word of the load.
- ld_done  out  1  one-cycle pulse in the cycle the load write is issued.
- ld_err  out  1  one-cycle pulse when ld_start arrives while not IDLE.
- busy_vec  out  16  bit i set while a load targeting vector register i is in flight.
- rf_we  out  1  to register file we3.
- rf_ra3  out  AW  to ra3.
- rf_wd3  out  LANES*DW  to wd3.
- rf_vs_w  out  1  to selec_v_s_w.
- rf_cmd  out  3  to cmd.

Behaviour:
- Reset values: state=IDLE; lane counter, starve counter, dst and buffer all 0; busy_vec=0; ld_ready, wb_stall, ld_done, ld_err=0. Reset mid-load discards the load and issues no write.
- Write-port mux (combinational, zero latency):
  - If wb_we=1: rf_* = wb_* (rf_vs_w=wb_vec).
  - Else if state=PEND: rf_we=1, rf_ra3=dst, rf_wd3=buffer, rf_vs_w=1, rf_cmd=3'b000. cmd 3'b101 is never used, because that encoding redirects the write to the scalar file.
  - Else: rf_we=0, all other rf_* outputs 0.
- IDLE:
  - ld_ready=0.
  - On ld_start: latch dst=ld_dst, clear buffer, lane=0, set busy_vec[ld_dst], go to FILL.
- FILL:
  - ld_ready=1.
  - On ld_valid&ld_ready: buffer[lane]=ld_data and lane++.
  - Word k lands in lane k; lane 0 is the first word.
  - Accepting a word with ld_last=1, or accepting the word for lane 15, moves to PEND.
  - ld_ready drops in the cycle after the 16th word. Lanes not written remain 0 (short load zero-fill).
- PEND:
  - ld_ready=0.
  - If wb_we=0 this cycle: the load write is driven. Pulse ld_done, clear busy_vec[dst], clear starve counter, go to IDLE.
  - If wb_we=1: increment the starve counter, saturating at STARVE_MAX.
  - wb_stall=1 while in PEND with starve counter == STARVE_MAX. It drops in the cycle after the grant.
  - If writeback ignores the stall, writeback still wins.
- ld_start while not IDLE: ignored, ld_err pulses, and the in-flight load is unaffected. ld_start in the same cycle as the PEND grant is also rejected.
- A writeback to dst while busy is allowed and is not blocked here; the later load write overwrites it. Decode uses busy_vec to prevent this.
- The register file samples writes on negedge, so rf_* settle within the high phase.

Decomposition:
- Shared package rf_pkg:
  - LANES, DW, AW.
  - vec_t (LANES×DW packed array).
  - Cmd constants, including CMD_VWRITE=3'b000 and CMD_VSCALAR=3'b101.
  - Load FSM enum {IDLE, FILL, PEND}.
- One natural sub-module: vload_gather, which holds the buffer, lane counter and ld_ready/ld_last handling. The top level holds the FSM, arbitration mux, starve counter and scoreboard.

Test Plan:
- Full load, no contention:
  - Stimulus: ld_start dst=3, words 1..16 back-to-back, last on the 16th, wb_we=0.
  - Response: one cycle after the 16th accept, rf_we=1, rf_ra3=3, lane k=k+1, rf_vs_w=1, rf_cmd=0.
  - ld_done pulses; busy_vec[3] is set from the start until the write.
- Short load:
  - Stimulus: dst=5, words 0xA,0xB,0xC with last on 0xC.
  - Response: write lanes 0..2 = A,B,C and lanes 3..15 = 0; ld_ready=0 after the 3rd accept.
- Contention:
  - Stimulus: load PEND with wb_we=1 held for 3 cycles (scalar, addr 2, data 0x11).
  - Response: wb passes through for those 3 cycles; the load writes in the 4th cycle; wb_stall never asserts.
- Starvation, STARVE_MAX=8:
  - Stimulus: wb_we=1 held continuously.
  - Response: wb_stall rises after 8 blocked cycles.
  - When wb_we drops, the load writes in that cycle and wb_stall falls the next cycle.
- Error and reset:
  - Stimulus: ld_start during FILL, then rst asserted mid-FILL.
  - Response: ld_err pulses once and the original dst is kept. After rst: busy_vec=0, state IDLE, and no rf_we from the load.
